// File: rtl/scic_io_port.sv
// scic_io_port: memory-mapped switch/LED responder for the SCIC I/O bus.
// Define SCIC_IO_IRQ_EN to build the writable irq_enable bit and the registered irq output.
module scic_io_port #(
   parameter logic [15:0] IO_BASE         = 16'hFFF0,
   parameter int          DEBOUNCE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [31:0] wdata,
   input  logic        rd_en,
   input  logic        wr_en,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic [3:0]  switches,
   output logic [3:0]  LEDs,
   output logic        irq
);
   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
   logic [3:0] s1, sync, stable;
   logic [7:0] cnt;
   logic [1:0] off;
   logic [31:0] rd_val;
   logic changed, hit, rd_hit, wr_hit, deb_done, irq_en, unused;
   assign off      = addr[1:0];
   assign hit      = (addr[15:2] == IO_BASE[15:2]) && (rd_en || wr_en);
   assign wr_hit   = hit && wr_en;
   assign rd_hit   = hit && !wr_en;
   assign deb_done = (sync != stable) && (cnt == CNT_MAX);
   assign unused   = ^wdata[31:4];
   always_comb begin
      rd_val = off == 2'd0 ? {28'b0, stable} :
               off == 2'd1 ? {30'b0, irq_en, changed} :
               off == 2'd2 ? {28'b0, LEDs} : 32'b0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         ready <= 1'b0;
         rdata <= 32'b0;
         LEDs  <= 4'b0;
      end else begin
         ready <= hit;
         rdata <= rd_hit ? rd_val : 32'b0;
         if (wr_hit && off == 2'd2) LEDs <= wdata[3:0];
         if (wr_hit && off == 2'd3) LEDs <= LEDs ^ wdata[3:0];
      end
   end
   // A debounce update on the same edge as an SW_DATA read keeps the flag set.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1      <= 4'b0;
         sync    <= 4'b0;
         stable  <= 4'b0;
         cnt     <= 8'b0;
         changed <= 1'b0;
      end else begin
         s1   <= switches;
         sync <= s1;
         cnt  <= (sync == stable || deb_done) ? 8'b0 : cnt + 8'd1;
         if (deb_done) stable <= sync;
         if (deb_done) changed <= 1'b1;
         else if (rd_hit && off == 2'd0) changed <= 1'b0;
      end
   end
`ifdef SCIC_IO_IRQ_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_hit && off == 2'd1) irq_en <= wdata[1];
         irq <= changed && irq_en;
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_scic_io_port.sv
// tb_scic_io_port: table-driven bus vectors plus hand sequences for debounce, flag race, irq and reset.
module tb_scic_io_port;
`ifdef SCIC_IO_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b1, rd_en = 1'b0, wr_en = 1'b0, ready, irq;
   logic [15:0] addr = 16'h0;
   logic [31:0] wdata = 32'h0, rdata;
   logic [3:0] switches = 4'hA, LEDs;
   int checks = 0, errors = 0;
   logic [31:0] got_d;
   logic got_r;

   typedef struct {
      logic        r, w;
      logic [15:0] a;
      logic [31:0] d;
      logic        rdy;
      logic [31:0] rd;
      logic [3:0]  led;
   } vec_t;
   vec_t tbl[16];

   scic_io_port dut (
      .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
      .rdata(rdata), .ready(ready), .switches(switches), .LEDs(LEDs), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic rdy);
      @(negedge clock);
      rd_en = r; wr_en = w; addr = a; wdata = d;
      tick();
      rd = rdata; rdy = ready;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 16'hFFF2, 32'h9,        1'b1, 32'h0, 4'h9};
      tbl[1]  = '{1'b0, 1'b1, 16'hFFF3, 32'h3,        1'b1, 32'h0, 4'hA};
      tbl[2]  = '{1'b1, 1'b0, 16'hFFF2, 32'h0,        1'b1, 32'hA, 4'hA};
      tbl[3]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h0, 4'hA};
      tbl[4]  = '{1'b0, 1'b1, 16'h0012, 32'h5,        1'b0, 32'h0, 4'hA};
      tbl[5]  = '{1'b1, 1'b1, 16'hFFF2, 32'h6,        1'b1, 32'h0, 4'h6};
      tbl[6]  = '{1'b1, 1'b0, 16'hFFF3, 32'h0,        1'b1, 32'h0, 4'h6};
      tbl[7]  = '{1'b1, 1'b0, 16'hFFF0, 32'h0,        1'b1, 32'hA, 4'h6};
      tbl[8]  = '{1'b0, 1'b1, 16'hFFF0, 32'h0,        1'b1, 32'h0, 4'h6};
      tbl[9]  = '{1'b1, 1'b0, 16'hFFF0, 32'h0,        1'b1, 32'hA, 4'h6};
      tbl[10] = '{1'b0, 1'b1, 16'hFFF1, 32'hFFFFFFFF, 1'b1, 32'h0, 4'h6};
      tbl[11] = '{1'b1, 1'b0, 16'hFFF1, 32'h0,        1'b1, IRQ_ON ? 32'h2 : 32'h0, 4'h6};
      tbl[12] = '{1'b0, 1'b1, 16'hFFF1, 32'h0,        1'b1, 32'h0, 4'h6};
      tbl[13] = '{1'b1, 1'b0, 16'hFFF6, 32'h0,        1'b0, 32'h0, 4'h6};
      tbl[14] = '{1'b0, 1'b1, 16'hFFF3, 32'hF,        1'b1, 32'h0, 4'h9};
      tbl[15] = '{1'b1, 1'b0, 16'hFFF2, 32'h0,        1'b1, 32'h9, 4'h9};

      repeat (3) tick();
      check("reset_leds", 32'(LEDs), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (10) tick();
      access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
      check("first_sw_data", got_d, 32'hA);
      access(1'b1, 1'b0, 16'hFFF1, 32'h0, got_d, got_r);
      check("status_cleared", got_d, 32'h0);
      tick();
      check("idle_ready", 32'(ready), 32'h0);

      for (int i = 0; i < 16; i++) begin
         access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, got_d, got_r);
         check($sformatf("vec%0d_ready", i), 32'(got_r), 32'(tbl[i].rdy));
         check($sformatf("vec%0d_rdata", i), got_d, tbl[i].rd);
         check($sformatf("vec%0d_leds", i), 32'(LEDs), 32'(tbl[i].led));
      end
      tick();
      check("ready_one_cycle", 32'(ready), 32'h0);
      check("rdata_idle_zero", rdata, 32'h0);

      // Settle switches at 0 and clear the changed flag.
      switches = 4'h0;
      repeat (10) tick();
      access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
      check("sw_zero", got_d, 32'h0);

      // Pin change before edge e1; stable updates on e6. Reads sample e2..e6, the last racing the update.
      @(negedge clock);
      switches = 4'h5;
      for (int k = 0; k < 5; k++) begin
         access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
         check($sformatf("deb_pre%0d", k), got_d, 32'h0);
      end
      access(1'b1, 1'b0, 16'hFFF1, 32'h0, got_d, got_r);
      check("race_changed_set", got_d, 32'h1);
      access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
      check("deb_new", got_d, 32'h5);
      access(1'b1, 1'b0, 16'hFFF1, 32'h0, got_d, got_r);
      check("changed_cleared", got_d, 32'h0);

      // Three-cycle glitch must not be accepted.
      @(negedge clock);
      switches = 4'hF;
      repeat (3) @(negedge clock);
      switches = 4'h5;
      repeat (10) tick();
      access(1'b1, 1'b0, 16'hFFF1, 32'h0, got_d, got_r);
      check("glitch_changed", got_d, 32'h0);
      access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
      check("glitch_sw", got_d, 32'h5);

      // Value moves mid-count; the final value is captured.
      @(negedge clock);
      switches = 4'h3;
      @(negedge clock);
      switches = 4'h6;
      repeat (10) tick();
      access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
      check("midcount_sw", got_d, 32'h6);

      // irq follows changed by one cycle when enabled; stays 0 without the feature.
      access(1'b0, 1'b1, 16'hFFF1, 32'h2, got_d, got_r);
      @(negedge clock);
      switches = 4'h9;
      for (int i = 1; i <= 7; i++) begin
         tick();
         check($sformatf("irq_e%0d", i), 32'(irq), 32'(IRQ_ON && i >= 7));
      end
      access(1'b1, 1'b0, 16'hFFF0, 32'h0, got_d, got_r);
      check("irq_sw", got_d, 32'h9);
      check("irq_hold", 32'(irq), 32'(IRQ_ON));
      tick();
      check("irq_drop", 32'(irq), 32'h0);

      // Reset asserted together with a request suppresses the ack.
      @(negedge clock);
      rd_en = 1'b1; addr = 16'hFFF0; reset = 1'b1;
      tick();
      check("reset_mid_ready", 32'(ready), 32'h0);
      check("reset_mid_leds", 32'(LEDs), 32'h0);
      rd_en = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      check("post_reset_ready", 32'(ready), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
